// File: rtl/option_fifo_pkg.sv
// Option-encoding definitions shared by the array-indexing stage,
// option_fifo and their benches. Tag lives in the MSB, 0 = Some, 1 = None.
package option_fifo_pkg;

    localparam int  OPT_PAYLOAD_W = 16;
    localparam int  OPT_W         = OPT_PAYLOAD_W + 1;

    localparam logic SOME_TAG = 1'b0;
    localparam logic NONE_TAG = 1'b1;

    // Canonical None word at the default payload width
    localparam logic [OPT_W-1:0] NONE_WORD = {NONE_TAG, {OPT_PAYLOAD_W{1'b0}}};

    // Option word width for a given payload width
    function automatic int opt_width(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/option_fifo_mem.sv
// DEPTH x W storage for option_fifo: one synchronous write port and one
// asynchronous read port. Ports: clk_i, we_i/waddr_i/wdata_i, raddr_i/rdata_o.
module option_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/option_fifo.sv
// Show-ahead FIFO behind the array-indexing stage: buffers Some payloads,
// discards None, presents the head Option-encoded and counts overflow drops.
// Ports: _i_clk, _i_rst (sync, active high), _i_in (Option), _i_pop,
//        __output (Option head), __count, __full, __dropped (saturating).
module option_fifo
    import option_fifo_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int W      = 16,
    parameter int DROP_W = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                    _i_clk,
    input  logic                    _i_rst,
    input  logic [opt_width(W)-1:0] _i_in,
    input  logic                    _i_pop,
    output logic [opt_width(W)-1:0] __output,
    output logic [CW-1:0]           __count,
    output logic                    __full,
    output logic [DROP_W-1:0]       __dropped
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("option_fifo: DEPTH must be a power of two >= 2");
    end

    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [W-1:0]      head;

    logic push_req;
    logic pop_ok;
    logic push_ok;
    logic full;
    logic empty;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = (_i_in[W] == SOME_TAG);
    assign pop_ok   = _i_pop && !empty;
    // A pop in the same cycle frees the slot the push needs
    assign push_ok  = push_req && (!full || pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        drop_d  = drop_q;
        if (push_ok) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push_req && !push_ok && !(&drop_q)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge _i_clk) begin
        if (_i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Writes are gated off during reset so storage never sees a stray push
    option_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_mem (
        .clk_i   (_i_clk),
        .we_i    (push_ok && !_i_rst),
        .waddr_i (wptr_q),
        .wdata_i (_i_in[W-1:0]),
        .raddr_i (rptr_q),
        .rdata_o (head)
    );

    assign __output  = empty ? {NONE_TAG, {W{1'b0}}} : {SOME_TAG, head};
    assign __count   = count_q;
    assign __full    = full;
    assign __dropped = drop_q;

endmodule

// File: tb/tb_option_fifo.sv
// Self-checking bench for option_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_option_fifo;

    localparam int DEPTH  = 4;
    localparam int W      = 16;
    localparam int DROP_W = 8;
    localparam logic [W:0] NONE = 17'h10000;

    logic        clk = 1'b0;
    logic        rst;
    logic [W:0]  din;
    logic        pop;
    logic [W:0]  dout;
    logic [2:0]  count;
    logic        full;
    logic [7:0]  dropped;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq[$];
    int           mdrop;

    option_fifo #(
        .DEPTH  (DEPTH),
        .W      (W),
        .DROP_W (DROP_W)
    ) dut (
        ._i_clk    (clk),
        ._i_rst    (rst),
        ._i_in     (din),
        ._i_pop    (pop),
        .__output  (dout),
        .__count   (count),
        .__full    (full),
        .__dropped (dropped)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] some(input int v);
        return {1'b0, 16'(v)};
    endfunction

    function automatic logic [W:0] m_out();
        return (mq.size() == 0) ? NONE : {1'b0, mq[0]};
    endfunction

    // One clock: drive inputs, let the edge pass, advance the model.
    task automatic cyc(input logic r, input logic [W:0] d, input logic p);
        bit pok;
        rst = r;
        din = d;
        pop = p;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mdrop = 0;
        end else begin
            pok = p && (mq.size() > 0);
            if (pok) void'(mq.pop_front());
            if (!d[W]) begin
                if (mq.size() < DEPTH) mq.push_back(d[W-1:0]);
                else if (mdrop < 255) mdrop++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b1, NONE, 1'b0);
        checks++;
        if (dout !== 17'h10000) begin
            errors++;
            $display("FAIL reset_out: got %h expected %h", dout, 17'h10000);
        end
        checks++;
        if (count !== 3'd0 || full !== 1'b0 || dropped !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got cnt=%0d full=%b drop=%0d expected 0/0/0",
                     count, full, dropped);
        end
    endtask

    task automatic test_fill_drain();
        int v[3] = '{11, 12, 13};
        cyc(1'b0, some(11), 1'b0);
        checks++;
        if (dout !== some(11)) begin
            errors++;
            $display("FAIL fd_first: got %h expected %h", dout, some(11));
        end
        cyc(1'b0, some(12), 1'b0);
        cyc(1'b0, some(13), 1'b0);
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL fd_count: got %0d expected 3", count);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout !== some(v[i])) begin
                errors++;
                $display("FAIL fd_head%0d: got %h expected %h", i, dout, some(v[i]));
            end
            cyc(1'b0, NONE, 1'b1);
        end
        checks++;
        if (dout !== NONE || count !== 3'd0) begin
            errors++;
            $display("FAIL fd_empty: got %h cnt=%0d expected %h cnt=0", dout, count, NONE);
        end
    endtask

    task automatic test_none_filter();
        cyc(1'b1, NONE, 1'b0);
        cyc(1'b0, NONE, 1'b0);
        cyc(1'b0, some(5), 1'b0);
        cyc(1'b0, NONE, 1'b0);
        cyc(1'b0, some(6), 1'b0);
        checks++;
        if (count !== 3'd2 || dout !== some(5) || dropped !== 8'd0) begin
            errors++;
            $display("FAIL none_filter: got cnt=%0d out=%h drop=%0d expected 2 %h 0",
                     count, dout, some(5), dropped);
        end
    endtask

    task automatic test_overflow();
        cyc(1'b1, NONE, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b0, some(i), 1'b0);
            if (i == 4) begin
                checks++;
                if (full !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_full: got %b expected 1", full);
                end
            end
        end
        checks++;
        if (dropped !== 8'd2 || count !== 3'd4) begin
            errors++;
            $display("FAIL ovf_drop: got drop=%0d cnt=%0d expected 2 4", dropped, count);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (dout !== some(i)) begin
                errors++;
                $display("FAIL ovf_drain%0d: got %h expected %h", i, dout, some(i));
            end
            cyc(1'b0, NONE, 1'b1);
        end
        checks++;
        if (dout !== NONE) begin
            errors++;
            $display("FAIL ovf_end: got %h expected %h", dout, NONE);
        end
    endtask

    task automatic test_full_pushpop();
        int v[4] = '{2, 3, 4, 9};
        logic [W:0] d;
        cyc(1'b1, NONE, 1'b0);
        for (int i = 1; i <= 4; i++) cyc(1'b0, some(i), 1'b0);
        cyc(1'b0, some(9), 1'b1);
        checks++;
        if (count !== 3'd4 || dropped !== 8'd0) begin
            errors++;
            $display("FAIL fpp_state: got cnt=%0d drop=%0d expected 4 0", count, dropped);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout !== some(v[i])) begin
                errors++;
                $display("FAIL fpp_drain%0d: got %h expected %h", i, dout, some(v[i]));
            end
            cyc(1'b0, NONE, 1'b1);
        end
        // Sustained push+pop at full walks both pointers around several times
        for (int i = 0; i < 4; i++) cyc(1'b0, some(100 + i), 1'b0);
        for (int i = 0; i < 12; i++) begin
            d = some($urandom_range(0, 65535));
            cyc(1'b0, d, 1'b1);
            checks++;
            if (dout !== m_out() || count !== 3'd4) begin
                errors++;
                $display("FAIL fpp_wrap%0d: got %h cnt=%0d expected %h cnt=4",
                         i, dout, count, m_out());
            end
        end
    endtask

    task automatic test_edges();
        cyc(1'b1, NONE, 1'b0);
        cyc(1'b0, NONE, 1'b1);
        checks++;
        if (dout !== NONE || count !== 3'd0) begin
            errors++;
            $display("FAIL pop_empty: got %h cnt=%0d expected %h cnt=0", dout, count, NONE);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, some(40 + i), 1'b0);
        cyc(1'b1, some(77), 1'b1);
        checks++;
        if (dout !== NONE || count !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: got %h cnt=%0d expected %h cnt=0", dout, count, NONE);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, some(i), 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b0, some(i), 1'b0);
        checks++;
        if (dropped !== 8'd255 || 32'(dropped) != mdrop) begin
            errors++;
            $display("FAIL drop_sat: got %0d expected 255", dropped);
        end
    endtask

    task automatic test_random();
        logic [W:0] d;
        logic       p;
        cyc(1'b1, NONE, 1'b0);
        for (int i = 0; i < 400; i++) begin
            d = ($urandom_range(0, 3) == 0) ? NONE : some($urandom_range(0, 65535));
            p = ($urandom_range(0, 9) < 4);
            cyc(1'b0, d, p);
            checks++;
            if (dout !== m_out() || 32'(count) != mq.size() ||
                full !== (mq.size() == DEPTH) || 32'(dropped) != mdrop) begin
                errors++;
                $display("FAIL rand%0d: got out=%h cnt=%0d full=%b drop=%0d expected %h %0d %b %0d",
                         i, dout, count, full, dropped, m_out(), mq.size(),
                         mq.size() == DEPTH, mdrop);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        din = NONE;
        pop = 1'b0;
        mdrop = 0;
        test_reset();
        test_fill_drain();
        test_none_filter();
        test_overflow();
        test_full_pushpop();
        test_edges();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/option_fifo.md
Name: option_fifo

Overview:
- Downstream consumer of the array-indexing stage.
- Each cycle it takes that stage's Option-encoded result, a 17-bit word: bit 16 is the tag (0 = Some, 1 = None) and bits 15:0 are the payload.
- Some payloads go into a small show-ahead FIFO. None words are discarded.
- The FIFO head is presented in the same Option encoding, so the next consumer sees None when nothing is buffered.

Parameters:
- DEPTH, 4: number of FIFO entries; must be a power of two, at least 2.
- W, 16: payload width; Option width is W+1.
- DROP_W, 8: width of the overflow-drop counter.

Ports:
- _i_clk  input  1  clock; all state updates on the rising edge.
- _i_rst  input  1  synchronous, active-high reset.
- _i_in  input  W+1  Option-encoded input: bit W = tag (0 = Some), bits W-1:0 = payload.
- _i_pop  input  1  consumer takes the head entry this cycle.
- __output  output  W+1  Option-encoded head: Some(head) when not empty, otherwise None.
- __count  output  clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.
- __full  output  1  high when count == DEPTH.
- __dropped  output  DROP_W  number of Some inputs lost to overflow; saturating.

Behaviour:
- Reset, synchronous on _i_rst high at a rising edge:
  - read and write pointers = 0, count = 0, dropped = 0;
  - __output = None encoding, i.e. tag 1 and payload 0 (17'h10000 at W = 16);
  - __full = 0;
  - storage contents are don't-care;
  - reset overrides any push or pop in the same cycle.
- Definitions:
  - push_req = (_i_in[W] == 0), i.e. the input is Some.
  - pop_ok = _i_pop && count != 0.
  - push_ok = push_req && (count != DEPTH || pop_ok).
- Push_ok: write the payload at wptr; wptr advances by 1 modulo DEPTH.
- Pop_ok: rptr advances by 1 modulo DEPTH.
- Count update:
  - +1 on push_ok alone;
  - -1 on pop_ok alone;
  - unchanged when both or neither.
- Full with simultaneous pop: the push is accepted; count stays at DEPTH.
- Full, push_req without pop: payload discarded and dropped increments by 1, saturating at 2^DROP_W-1. Storage and pointers are unchanged.
- Input None: no write, no drop count, no state change apart from any pop.
- Pop on empty: ignored, no underflow, output remains None.
- Push and pop while count == 1: the popped entry leaves, the new entry becomes head next cycle, count stays 1.
- Output timing:
  - __output, __count, __full are functions of registered state only; there is no combinational path from _i_in or _i_pop.
  - A pushed value appears on __output on the cycle after the push edge.
  - Head-to-head latency through an empty FIFO is one cycle.
- Ordering: strict FIFO; payloads leave in acceptance order.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. Full/empty is determined by count, not by pointer comparison.

Decomposition:
- Shared package contents:
  - Option tag constants: SOME_TAG = 0, NONE_TAG = 1.
  - Helper constant NONE_WORD: tag 1, payload 0.
  - Option-encoding width rule: W+1, tag in the MSB.
  - These are reused by the array-indexing stage and its benches.
- One natural sub-module, option_fifo_mem:
  - DEPTH x W register array, one write port, one asynchronous read port;
  - no reset on storage.
- Control (pointers, count, drop counter, Option packing) stays in the top.

Test Plan:
1. Reset then idle:
   - Stimulus: assert _i_rst one cycle, _i_in = None, _i_pop = 0.
   - Required: __output = 17'h10000, __count = 0, __full = 0, __dropped = 0.
2. Ordered fill and drain:
   - Stimulus: push Some(11), Some(12), Some(13) on consecutive cycles, no pop.
   - Required: __output = Some(11) one cycle after the first push, count reaches 3.
   - Then pop three cycles: head reads 11, then 12, then 13, then None; count returns to 0.
3. None filtering:
   - Stimulus: interleave None, Some(5), None, Some(6).
   - Required: count = 2, head Some(5), __dropped stays 0.
4. Overflow:
   - Stimulus: push Some(1)..Some(6) with no pop.
   - Required: __full = 1 after the 4th push, __dropped = 2.
   - Draining then yields 1, 2, 3, 4 only.
5. Full with simultaneous push and pop:
   - Stimulus: start full holding 1..4; push Some(9) with _i_pop = 1.
   - Required: count stays 4, __dropped unchanged, drain order 2, 3, 4, 9.
   - Run long enough that the pointers wrap at least twice.
6. Edge cases:
   - Pop on empty: __output stays None and count stays 0.
   - Reset mid-operation with count = 3: the next cycle shows None, count 0.
   - Drop saturation: 300 overflow pushes leave __dropped = 255.
